seg7_digit_scanner: RTL and testbench
=====================================

Name: seg7_digit_scanner

Overview:
Downstream display stage for the decade counter / 7-segment decoder designs. Takes NUM_DIGITS packed BCD digits plus decimal-point bits and time-multiplexes them onto one shared segment bus. It drives one-hot digit enables, with a dead-time blanking slot between digits to prevent ghosting. It also provides double-buffered loading, optional leading-zero blanking and a frame-done strobe.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
SCAN_DIV, 1024, clock cycles per digit slot, including blanking (>=2)
BLANK_CYCLES, 16, dead-time cycles at the start of each slot (1..SCAN_DIV-1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset
en  input  1  scan enable; 0 = display dark
load  input  1  single-cycle strobe; captures bcd_in/dp_in into the pending buffer
bcd_in  input  4*NUM_DIGITS  digit i at bits [4i+3:4i]; digit 0 is least significant
dp_in  input  NUM_DIGITS  decimal point per digit
lz_blank  input  1  leading-zero blanking enable
seg_out  output  7  segments a..g on bits 0..6, active high
dp_out  output  1  decimal point, active high
dig_en  output  NUM_DIGITS  one-hot digit enable, active high
frame_done  output  1  one-cycle pulse at the end of the last digit slot

Interface (decided): one clock; reset is asynchronous and active-low. All logic is clocked on the rising edge of clk. rst_n low asynchronously clears every flop.

Behaviour:
- Reset values:
  - seg_out=0, dp_out=0, dig_en=0, frame_done=0.
  - Pending and active buffers = 0.
  - Digit index = 0, slot counter = 0, state = IDLE.
- All outputs are registered, with no combinational paths from inputs to outputs.
- States:
  - IDLE: outputs dark. On en=1, go to BLANK with index 0 and counter 0.
  - BLANK: dig_en=0, seg_out=0, dp_out=0. After BLANK_CYCLES cycles, go to SHOW.
  - SHOW: dig_en has a single bit set at the current index. seg_out and dp_out show the active digit. Lasts SCAN_DIV-BLANK_CYCLES cycles.
- Slot end: index increments and the FSM returns to BLANK. When index=NUM_DIGITS-1, index wraps to 0 and frame_done pulses for one cycle.
- Frame period: exactly NUM_DIGITS*SCAN_DIV cycles.
- Visible latency: outputs reflect the state one cycle after the state flop changes.
- en=0 in any state:
  - Next cycle: state=IDLE, all outputs 0, index and counter cleared, no frame_done.
  - Buffers are kept.
  - Re-enabling restarts at digit 0 BLANK.
- Buffering:
  - load writes the pending buffer at any time.
  - Active <= pending on the cycle frame_done is asserted.
  - If load coincides with that cycle, the new bcd_in/dp_in go straight to active as well as pending.
  - A mid-frame load never changes the digits of the current frame.
  - While IDLE, active <= pending on every cycle.
- Decode:
  - 0..9 map to 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
  - 10..15 map to 0x00 (blank).
- Leading-zero blanking, when lz_blank=1:
  - Digit i is blanked (seg=0) if it and every more-significant digit are 0.
  - Digit 0 is never blanked.
  - dp_out is unaffected by blanking.
  - Evaluated on the active buffer.
- Slot counter width is clog2(SCAN_DIV). Counter and index wrap with no overflow state.

Decomposition:
- Package seg7_pkg holds:
  - The SEG_* segment code constants and SEG_BLANK.
  - The scanner state enum (IDLE/BLANK/SHOW).
  - A bcd_to_seg function.
- One sub-module, seg7_bcd_decode: combinational 4-bit to 7-segment decoder, also reusable by the counter designs.

Test Plan:
(Parameters for all tests: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
1. Assert rst_n=0 mid-SHOW -> same instant seg_out=0, dig_en=0, frame_done=0. After release with en=1, digit 0 BLANK restarts.
2. Load bcd_in=0x1234, dp_in=0b0100, en=1:
   - Each slot is 2 dark cycles, then 6 cycles of dig_en=0001 seg 0x66, then 0010 0x4F, then 0100 0x5B with dp_out=1, then 1000 0x06.
   - frame_done fires every 32 cycles.
3. bcd_in=0x0050:
   - lz_blank=1 -> digits 3,2 show seg=0; digit 1 shows 0x6D; digit 0 shows 0x3F.
   - lz_blank=0 -> digits 3,2 show 0x3F.
4. bcd_in=0x0A0F, lz_blank=0 -> digits 2 and 0 show seg=0; digits 3 and 1 show 0x3F.
5. Load 0x9999 during digit 1 SHOW of a 0x1234 frame -> the rest of the frame shows 2,1. The next frame shows 0x6F on all digits. Load coinciding with frame_done -> the new value appears in the next frame.
6. Drop en mid-SHOW for 3 cycles -> outputs 0 from the next cycle with no frame_done. On re-enable, the first lit digit is digit 0 after 2 blank cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment codes, scanner state encoding and
// the BCD-to-segment mapping used by the decoder and scanner.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Non-decimal codes render dark rather than as hex glyphs.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational 4-bit BCD to 7-segment decoder (segments a..g on bits 0..6).
module seg7_bcd_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup through the shared mapping.
  always_comb begin
    seg = bcd_to_seg(bcd);
  end

endmodule

// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed 7-segment scanner: one shared segment bus, one-hot digit
// enables, dead-time blanking per slot and frame-aligned double buffering.
module seg7_digit_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

  scan_state_e               state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [4*NUM_DIGITS-1:0]   pend_bcd_r;
  logic [NUM_DIGITS-1:0]     pend_dp_r;
  logic [4*NUM_DIGITS-1:0]   act_bcd_r;
  logic [NUM_DIGITS-1:0]     act_dp_r;
  logic [6:0]                seg_r;
  logic                      dp_r;
  logic [NUM_DIGITS-1:0]     dig_en_r;
  logic                      frame_done_r;

  logic [3:0]                cur_bcd_s;
  logic [6:0]                dec_seg_s;
  logic                      upper_zero_s;
  logic [6:0]                show_seg_s;

  assign cur_bcd_s    = act_bcd_r[{idx_r, 2'b00} +: 4];
  assign upper_zero_s = ((act_bcd_r >> {idx_r, 2'b00}) == {(4*NUM_DIGITS){1'b0}});

  seg7_bcd_decode u_decode (
    .bcd (cur_bcd_s),
    .seg (dec_seg_s)
  );

  // Leading-zero suppression: digit 0 always stays lit so a zero value is visible.
  always_comb begin
    show_seg_s = dec_seg_s;
    if (lz_blank && (idx_r != IDX_ZERO) && upper_zero_s) begin
      show_seg_s = SEG_BLANK;
    end else begin
      show_seg_s = dec_seg_s;
    end
  end

  // Pending/active buffers; active only changes while idle or at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd_r <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r  <= {NUM_DIGITS{1'b0}};
      act_bcd_r  <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r   <= {NUM_DIGITS{1'b0}};
    end else begin
      if (load) begin
        pend_bcd_r <= bcd_in;
        pend_dp_r  <= dp_in;
      end
      if ((state_r == IDLE) || frame_done_r) begin
        act_bcd_r <= load ? bcd_in : pend_bcd_r;
        act_dp_r  <= load ? dp_in  : pend_dp_r;
      end
    end
  end

  // Scan FSM with registered outputs; outputs follow the state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= IDX_ZERO;
      cnt_r        <= CNT_ZERO;
      seg_r        <= SEG_BLANK;
      dp_r         <= 1'b0;
      dig_en_r     <= {NUM_DIGITS{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      seg_r        <= SEG_BLANK;
      dp_r         <= 1'b0;
      dig_en_r     <= {NUM_DIGITS{1'b0}};
      if (!en) begin
        state_r <= IDLE;
        idx_r   <= IDX_ZERO;
        cnt_r   <= CNT_ZERO;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= BLANK;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
          end
          BLANK: begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == BLANK_LAST) begin
              state_r <= SHOW;
            end
          end
          SHOW: begin
            seg_r    <= show_seg_s;
            dp_r     <= act_dp_r[idx_r];
            dig_en_r <= DIG_ONE << idx_r;
            if (cnt_r == SLOT_LAST) begin
              cnt_r   <= CNT_ZERO;
              state_r <= BLANK;
              if (idx_r == IDX_LAST) begin
                idx_r        <= IDX_ZERO;
                frame_done_r <= 1'b1;
              end else begin
                idx_r <= idx_r + IDX_ONE;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign dig_en     = dig_en_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Self-checking bench for seg7_digit_scanner against a frame-position model.
module tb_seg7_digit_scanner;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_en;
  logic        frame_done;

  seg7_digit_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: m_k is the output position since the scan was (re)started.
  bit          m_run;
  int          m_k;
  logic [15:0] m_pend_bcd, m_frame_bcd;
  logic [3:0]  m_pend_dp, m_frame_dp;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  function automatic logic [12:0] model_out();
    int pos, d, w;
    logic [15:0] upper;
    logic [6:0]  s;
    logic        fd;
    if (!m_run || m_k < 0) return 13'h0;
    pos = m_k % FRAME;
    d   = pos / SD;
    w   = pos % SD;
    fd  = (pos == FRAME - 1);
    if (w < BC) return {fd, 12'h0};
    upper = m_frame_bcd >> (4 * d);
    s = seg_tab[upper[3:0]];
    if (lz_blank && d != 0 && upper == 16'h0) s = 7'h00;
    return {fd, 4'(1 << d), m_frame_dp[d], s};
  endfunction

  function automatic logic [12:0] dut_out();
    return {frame_done, dig_en, dp_out, seg_out};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_k = -1;
    m_pend_bcd = 16'h0; m_pend_dp = 4'h0;
    m_frame_bcd = 16'h0; m_frame_dp = 4'h0;
  endtask

  task automatic tick();
    logic l, e;
    logic [15:0] b;
    logic [3:0]  p;
    l = load; e = en; b = bcd_in; p = dp_in;
    @(posedge clk);
    if (l) begin m_pend_bcd = b; m_pend_dp = p; end
    if (!e) begin
      m_run = 1'b0; m_k = -1;
    end else if (!m_run) begin
      m_run = 1'b1; m_k = -1;
      m_frame_bcd = m_pend_bcd; m_frame_dp = m_pend_dp;
    end else begin
      m_k++;
      if (m_k > 0 && m_k % FRAME == 0) begin
        m_frame_bcd = m_pend_bcd; m_frame_dp = m_pend_dp;
      end
    end
    #1;
  endtask

  task automatic restart(input logic [15:0] b, input logic [3:0] p);
    en = 1'b0; tick();
    load = 1'b1; bcd_in = b; dp_in = p; tick();
    load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if (dut_out() !== 13'h0) $display("FAIL reset_hold got %h want %h", dut_out(), 13'h0);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL reset_idle got %h want %h", dut_out(), model_out());
      else passed++;
    end
  endtask

  task automatic test_pattern();
    int last, npulse;
    last = -1; npulse = 0;
    lz_blank = 1'b0;
    restart(16'h1234, 4'b0100);
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL pattern k=%0d got %h want %h", m_k, dut_out(), model_out());
      else passed++;
      if (frame_done) begin
        npulse++;
        if (last >= 0) begin
          checks++;
          if (i - last !== FRAME) $display("FAIL frame_period got %0d want %0d", i - last, FRAME);
          else passed++;
        end
        last = i;
      end
    end
    checks++;
    if (npulse !== 3) $display("FAIL frame_count got %0d want %0d", npulse, 3);
    else passed++;
  endtask

  task automatic test_lz();
    lz_blank = 1'b1;
    restart(16'h0050, 4'b0000);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) lz_blank = 1'b0;
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL lz_blank lz=%0d k=%0d got %h want %h", lz_blank, m_k, dut_out(), model_out());
      else passed++;
    end
  endtask

  task automatic test_hex();
    lz_blank = 1'b0;
    restart(16'h0A0F, 4'b1010);
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL hex_blank k=%0d got %h want %h", m_k, dut_out(), model_out());
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    lz_blank = 1'b0;
    restart(16'h1234, 4'b0000);
    for (int i = 0; i < 110; i++) begin
      load = 1'b0;
      if (m_k == SD + BC + 1) begin load = 1'b1; bcd_in = 16'h9999; dp_in = 4'b1111; end
      if (m_k == 2 * FRAME - 1) begin load = 1'b1; bcd_in = 16'h5678; dp_in = 4'b0001; end
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL midload k=%0d got %h want %h", m_k, dut_out(), model_out());
      else passed++;
    end
    load = 1'b0;
  endtask

  task automatic test_en_drop();
    restart(16'h1234, 4'b0100);
    for (int i = 0; i < 60; i++) begin
      if (m_k == SD + BC + 2) en = 1'b0;
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL en_drop en=%0d k=%0d got %h want %h", en, m_k, dut_out(), model_out());
      else passed++;
      if (!en && i > 0 && ((i % 64) == 0 || !m_run)) begin
        if (dut_out() === 13'h0 && frame_done === 1'b0 && !en) begin
          // leave en low exactly three cycles
        end
      end
      if (!en && !m_run) begin
        for (int j = 0; j < 2; j++) begin
          tick();
          checks++;
          if (dut_out() !== 13'h0) $display("FAIL en_dark got %h want %h", dut_out(), 13'h0);
          else passed++;
        end
        en = 1'b1;
      end
    end
  endtask

  task automatic test_reset_midshow();
    restart(16'h4321, 4'b0001);
    while (m_k != 20) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL pre_reset k=%0d got %h want %h", m_k, dut_out(), model_out());
      else passed++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_out() !== 13'h0) $display("FAIL async_reset got %h want %h", dut_out(), 13'h0);
    else passed++;
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL post_reset k=%0d got %h want %h", m_k, dut_out(), model_out());
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 5) == 0);
      for (int n = 0; n < 4; n++) b[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      bcd_in = b;
      dp_in  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      en = ($urandom_range(0, 79) != 0);
      tick();
      checks++;
      if (dut_out() !== model_out()) $display("FAIL random i=%0d k=%0d got %h want %h", i, m_k, dut_out(), model_out());
      else passed++;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_lz();
    test_hex();
    test_back_to_back();
    test_en_drop();
    test_reset_midshow();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
